maze_agent: RTL and testbench

Closed-loop controller that drives the `controllable_leftright` input of the maze planning block.
- Keeps a cycle-exact shadow of the maze's x/y position from the observed `updown` stimulus and its own moves.
- Steers x to the goal column while never entering the error cell.
- Cross-checks the maze's `error`/`objective` outputs against the shadow and reports episode outcome, step count and desync to the test harness.

---
 rtl/maze_pkg.sv | 11 +
 rtl/maze_shadow.sv | 41 ++++
 rtl/maze_agent.sv | 84 ++++++++
 tb/tb_maze_agent.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared types and default geometry for the maze agent.
package maze_pkg;
    localparam int CW            = 4;
    localparam int K_DEF         = 5;
    localparam int GOAL_X_DEF    = 2;
    localparam int ERR_X_DEF     = 2;
    localparam int ERR_Y_DEF     = 2;
    localparam int MAX_STEPS_DEF = 16;
    typedef enum logic [1:0] {INIT, RUN, WIN, LOSE} state_t;
    typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/maze_shadow.sv
// maze_shadow: cycle-exact copy of the maze's x/y position update rules.
module maze_shadow
    import maze_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   enable,
    input  logic   updown,
    input  logic   leftright,
    output coord_t sx,
    output coord_t sy,
    output logic   first
);
    localparam coord_t KM1 = coord_t'(K - 1);
    coord_t r_sx, r_sy, w_nx, w_ny;
    logic   r_first, w_frozen;
    assign w_frozen = (r_sx == KM1) && (r_sy < KM1);
    assign w_ny = (!updown && r_sy < KM1) ? r_sy + 4'd1 : (updown && r_sy > 4'd0) ? r_sy - 4'd1 : r_sy;
    assign w_nx = (!leftright && r_sx > 4'd0) ? r_sx - 4'd1 : (leftright && r_sx < KM1) ? r_sx + 4'd1 : r_sx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_first <= 1'b1;
        end else if (enable) begin
            if (r_first) begin
                r_sx    <= '0;
                r_sy    <= 4'd2;
                r_first <= 1'b0;
            end else if (!w_frozen) begin
                r_sx <= w_nx;
                r_sy <= w_ny;
            end
        end
    end
    assign sx    = r_sx;
    assign sy    = r_sy;
    assign first = r_first;
endmodule

// File: rtl/maze_agent.sv
// maze_agent: steers the maze toward the goal column, avoiding the error cell,
// and cross-checks the maze outputs against a local shadow of its position.
module maze_agent
    import maze_pkg::*;
#(
    parameter int K         = K_DEF,
    parameter int GOAL_X    = GOAL_X_DEF,
    parameter int ERR_X     = ERR_X_DEF,
    parameter int ERR_Y     = ERR_Y_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       updown,
    input  logic       error_in,
    input  logic       objective_in,
    output logic       leftright,
    output logic       done,
    output logic       success,
    output logic       desync,
    output logic [4:0] step_cnt
);
    state_t     r_state, w_next;
    coord_t     w_sx, w_sy;
    logic       w_first, w_danger, w_policy, w_inc, w_mismatch;
    logic       r_done, r_success, r_desync;
    logic [4:0] r_step;

    maze_shadow #(.K(K)) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (r_state == INIT || r_state == RUN),
        .updown    (updown),
        .leftright (leftright),
        .sx        (w_sx),
        .sy        (w_sy),
        .first     (w_first)
    );

    // Danger: y could land on the error row at the next edge.
    assign w_danger = (int'(w_sy) + 1 >= ERR_Y) && (int'(w_sy) <= ERR_Y + 1);
    assign w_policy = (int'(w_sx) < GOAL_X) ? !(int'(w_sx) == ERR_X - 1 && w_danger)
                    : (int'(w_sx) > GOAL_X) ? (int'(w_sx) == ERR_X + 1 && w_danger)
                    : 1'b1;
    assign leftright  = (r_state == WIN || r_state == LOSE) ? 1'b0 : w_policy;
    assign w_mismatch = (objective_in != (int'(w_sx) == GOAL_X))
                     || (error_in != (int'(w_sx) == ERR_X && int'(w_sy) == ERR_Y));

    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        case (r_state)
            INIT: w_next = RUN;
            RUN: begin
                if (error_in)                         w_next = LOSE;
                else if (objective_in)                w_next = WIN;
                else if (r_step == 5'(MAX_STEPS - 1)) w_next = LOSE;
                else                                  w_inc  = 1'b1;
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= INIT;
            r_step    <= '0;
            r_done    <= 1'b0;
            r_success <= 1'b0;
            r_desync  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_step    <= (w_inc && r_step != 5'd31) ? r_step + 5'd1 : r_step;
            r_done    <= r_done | (r_state == RUN && w_next != RUN);
            r_success <= r_success | (r_state == RUN && w_next == WIN);
            r_desync  <= r_desync | (r_state == RUN && w_mismatch);
        end
    end

    assign done     = r_done;
    assign success  = r_success;
    assign desync   = r_desync;
    assign step_cnt = r_step;
endmodule

// File: tb/tb_maze_agent.sv
// tb_maze_agent: directed episodes against a behavioural maze, checking outcome,
// step count, desync and steering against hand-computed trajectories.
module tb_maze_agent;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       updown = 1'b1;
    logic       error_in, objective_in, leftright, done, success, desync;
    logic [4:0] step_cnt;
    logic       ovr = 1'b0, ovr_e = 1'b0, ovr_o = 1'b0, saw_err;
    logic [3:0] mx, my;
    logic       mfirst;
    int         vec = 0, miss = 0;

    always #5 clk = ~clk;

    maze_agent dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .updown       (updown),
        .error_in     (error_in),
        .objective_in (objective_in),
        .leftright    (leftright),
        .done         (done),
        .success      (success),
        .desync       (desync),
        .step_cnt     (step_cnt)
    );

    // Behavioural maze: K=5, goal column 2, error cell (2,2).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx <= 0; my <= 0; mfirst <= 1'b1;
        end else if (mfirst) begin
            mx <= 0; my <= 2; mfirst <= 1'b0;
        end else if (!(mx == 4 && my < 4)) begin
            my <= (!updown && my < 4) ? my + 1 : (updown && my > 0) ? my - 1 : my;
            mx <= (!leftright && mx > 0) ? mx - 1 : (leftright && mx < 4) ? mx + 1 : mx;
        end
    end
    assign error_in     = ovr ? ovr_e : (mx == 2 && my == 2);
    assign objective_in = ovr ? ovr_o : (mx == 2);

    task automatic edge_(input logic ud);
        updown = ud;
        @(negedge clk);
        if (error_in) saw_err = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ovr = 1'b0; updown = 1'b1; saw_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec++; if (leftright !== 1'b1) begin miss++; $display("FAIL reset_lr got %b want 1", leftright); end
        vec++; if (done !== 1'b0) begin miss++; $display("FAIL reset_done got %b want 0", done); end
        vec++; if (success !== 1'b0) begin miss++; $display("FAIL reset_success got %b want 0", success); end
        vec++; if (desync !== 1'b0) begin miss++; $display("FAIL reset_desync got %b want 0", desync); end
        vec++; if (step_cnt !== 5'd0) begin miss++; $display("FAIL reset_step got %0d want 0", step_cnt); end
    endtask

    // y walks 2,1,0; dodge at (1,1), then (0,0),(1,0),(2,0) -> WIN after 6 edges.
    task automatic test_updown_high();
        int n = 0;
        do_reset();
        edge_(1'b1); n++;
        vec++; if (leftright !== 1'b1) begin miss++; $display("FAIL hi_lr_e1 got %b want 1", leftright); end
        edge_(1'b1); n++;
        vec++; if (leftright !== 1'b0) begin miss++; $display("FAIL hi_lr_e2 got %b want 0", leftright); end
        while (!done && n < 40) begin edge_(1'b1); n++; end
        vec++; if (n !== 6) begin miss++; $display("FAIL hi_edges got %0d want 6", n); end
        vec++; if (success !== 1'b1) begin miss++; $display("FAIL hi_success got %b want 1", success); end
        vec++; if (step_cnt !== 5'd4) begin miss++; $display("FAIL hi_step got %0d want 4", step_cnt); end
        vec++; if (desync !== 1'b0) begin miss++; $display("FAIL hi_desync got %b want 0", desync); end
        vec++; if (leftright !== 1'b0) begin miss++; $display("FAIL hi_lr_term got %b want 0", leftright); end
        ovr = 1'b1; ovr_e = 1'b1; ovr_o = 1'b0;
        repeat (3) edge_(1'b0);
        ovr = 1'b0;
        vec++; if ({done, success, desync} !== 3'b110) begin miss++; $display("FAIL hi_sticky got %b want 110", {done, success, desync}); end
        vec++; if (step_cnt !== 5'd4) begin miss++; $display("FAIL hi_step_hold got %0d want 4", step_cnt); end
    endtask

    // y rises 2,3,4; dodge at (1,3), then (0,4),(1,4),(2,4) -> WIN.
    task automatic test_updown_low();
        int n = 0;
        logic [3:0] lr_seq;
        do_reset();
        for (int i = 0; i < 4; i++) begin edge_(1'b0); n++; lr_seq[i] = leftright; end
        vec++; if (lr_seq !== 4'b1101) begin miss++; $display("FAIL lo_lr_seq got %b want 1101", lr_seq); end
        while (!done && n < 40) begin edge_(1'b0); n++; end
        vec++; if (n !== 6) begin miss++; $display("FAIL lo_edges got %0d want 6", n); end
        vec++; if (success !== 1'b1) begin miss++; $display("FAIL lo_success got %b want 1", success); end
        vec++; if (step_cnt !== 5'd4) begin miss++; $display("FAIL lo_step got %0d want 4", step_cnt); end
        vec++; if (desync !== 1'b0) begin miss++; $display("FAIL lo_desync got %b want 0", desync); end
    endtask

    // y oscillates 2<->3, x dithers 0<->1 until the step budget is exhausted.
    task automatic test_dither();
        int n = 0;
        do_reset();
        edge_(1'b1); n++;
        while (!done && n < 40) begin edge_(n[0] ? 1'b0 : 1'b1); n++; end
        vec++; if (n !== 17) begin miss++; $display("FAIL dith_edges got %0d want 17", n); end
        vec++; if (success !== 1'b0) begin miss++; $display("FAIL dith_success got %b want 0", success); end
        vec++; if (step_cnt !== 5'd15) begin miss++; $display("FAIL dith_step got %0d want 15", step_cnt); end
        vec++; if (saw_err !== 1'b0) begin miss++; $display("FAIL dith_err got %b want 0", saw_err); end
        vec++; if (desync !== 1'b0) begin miss++; $display("FAIL dith_desync got %b want 0", desync); end
    endtask

    task automatic test_error_force();
        do_reset();
        edge_(1'b1);
        ovr = 1'b1; ovr_e = 1'b1; ovr_o = 1'b1;
        edge_(1'b1);
        ovr = 1'b0;
        vec++; if ({done, success, desync} !== 3'b101) begin miss++; $display("FAIL errf_flags got %b want 101", {done, success, desync}); end
        vec++; if (step_cnt !== 5'd0) begin miss++; $display("FAIL errf_step got %0d want 0", step_cnt); end
    endtask

    task automatic test_objective_force();
        do_reset();
        edge_(1'b0);
        edge_(1'b0);
        ovr = 1'b1; ovr_e = 1'b0; ovr_o = 1'b1;
        edge_(1'b0);
        ovr = 1'b0;
        vec++; if ({done, success, desync} !== 3'b111) begin miss++; $display("FAIL objf_flags got %b want 111", {done, success, desync}); end
        vec++; if (step_cnt !== 5'd1) begin miss++; $display("FAIL objf_step got %0d want 1", step_cnt); end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        do_reset();
        repeat (4) edge_(1'b0);
        vec++; if (step_cnt !== 5'd3) begin miss++; $display("FAIL mid_pre_step got %0d want 3", step_cnt); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({leftright, done, success, desync} !== 4'b1000) begin miss++; $display("FAIL mid_flags got %b want 1000", {leftright, done, success, desync}); end
        vec++; if (step_cnt !== 5'd0) begin miss++; $display("FAIL mid_step got %0d want 0", step_cnt); end
        @(negedge clk);
        rst_n = 1'b1; saw_err = 1'b0;
        while (!done && n < 40) begin edge_(1'b0); n++; end
        vec++; if (n !== 6) begin miss++; $display("FAIL mid_edges got %0d want 6", n); end
        vec++; if ({success, desync, step_cnt} !== {2'b10, 5'd4}) begin miss++; $display("FAIL mid_rerun got s=%b d=%b n=%0d want s=1 d=0 n=4", success, desync, step_cnt); end
    endtask

    initial begin
        test_reset();
        test_updown_high();
        test_updown_low();
        test_dither();
        test_error_force();
        test_objective_force();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
